// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-bus sequencer: register word
// addresses, CTRL bit fields, sequencer state encoding and the bus payload.
package uart_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  // Register word addresses (byte address >> 2)
  localparam logic [ADDR_W-1:0] ADDR_DATA = 10'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 10'd2;
  localparam logic [ADDR_W-1:0] ADDR_BAUD = 10'd4;

  // CTRL register fields
  localparam int unsigned        CTRL_TX_EN_BIT  = 0;
  localparam logic [DATA_W-1:0]  CTRL_TX_EN_WORD = DATA_W'(1) << CTRL_TX_EN_BIT;

  typedef enum logic [3:0] {
    ST_UNCFG       = 4'd0,
    ST_BAUD_SETUP  = 4'd1,
    ST_BAUD_ACCESS = 4'd2,
    ST_CTRL_SETUP  = 4'd3,
    ST_CTRL_ACCESS = 4'd4,
    ST_RUN         = 4'd5,
    ST_DATA_SETUP  = 4'd6,
    ST_DATA_ACCESS = 4'd7,
    ST_DATA_GAP    = 4'd8
  } seq_state_e;

  // Register-bus master payload
  typedef struct packed {
    logic              sel;
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_bus_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the sequencer.
// Ports: push/wr_data (guarded internally by ready), pop (guarded by !empty),
// rd_data_c = combinational head, ready = not full, empty, level (registered),
// level_nxt_c = occupancy after this cycle's push/pop.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       ready,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointer/level update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    do_push  = push && ready_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = do_push ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop  ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d  = LVL_W'(level_q + LVL_W'(do_push) - LVL_W'(do_pop));
    ready_d  = (level_d != LVL_W'(DEPTH));
    empty_d  = (level_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c   = mem_q[rd_ptr_q];
  assign ready       = ready_q;
  assign empty       = empty_q;
  assign level       = level_q;
  assign level_nxt_c = level_d;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Register-bus master that programs the UART (BAUDDIV, then CTRL) and then
// drains a byte FIFO into DATA, one byte per transmitter-idle window.
// Ports: cfg_start/cfg_baud (configuration request), byte_valid/byte_data/
// byte_ready (client push), tx_busy (UART status), sel/enable/addr/write/wdata
// (two-cycle register bus), cfg_done, fifo_level, idle (status).
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       BAUD_W     = 16,
  parameter logic [DATA_W-1:0] CTRL_TX_EN = CTRL_TX_EN_WORD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_start,
  input  logic [BAUD_W-1:0]           cfg_baud,
  input  logic                        byte_valid,
  input  logic [BYTE_W-1:0]           byte_data,
  output logic                        byte_ready,
  input  logic                        tx_busy,
  output logic                        sel,
  output logic                        enable,
  output logic [ADDR_W-1:0]           addr,
  output logic                        write,
  output logic [DATA_W-1:0]           wdata,
  output logic                        cfg_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e        state_q, state_d;
  reg_bus_t          bus_q, bus_d;
  logic              cfg_done_q, cfg_done_d;
  logic              idle_q, idle_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_ready;
  logic [BYTE_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_lvl;
  logic [LVL_W-1:0]  fifo_lvl_nxt;

  assign fifo_push = byte_valid && fifo_ready;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .wr_data     (byte_data),
    .pop         (fifo_pop),
    .rd_data_c   (fifo_head),
    .ready       (fifo_ready),
    .empty       (fifo_empty),
    .level       (fifo_lvl),
    .level_nxt_c (fifo_lvl_nxt)
  );

  // Next state, bus payload and status for the following cycle
  always_comb begin
    state_d       = state_q;
    bus_d         = bus_q;
    bus_d.sel     = 1'b0;
    bus_d.enable  = 1'b0;
    bus_d.write   = 1'b0;
    cfg_done_d    = cfg_done_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      ST_UNCFG: begin
        if (cfg_start) begin
          state_d     = ST_BAUD_SETUP;
          cfg_done_d  = 1'b0;
          bus_d.addr  = ADDR_BAUD;
          bus_d.wdata = DATA_W'(cfg_baud);
        end
      end
      ST_BAUD_SETUP:  state_d = ST_BAUD_ACCESS;
      ST_BAUD_ACCESS: begin
        state_d     = ST_CTRL_SETUP;
        bus_d.addr  = ADDR_CTRL;
        bus_d.wdata = CTRL_TX_EN;
      end
      ST_CTRL_SETUP:  state_d = ST_CTRL_ACCESS;
      ST_CTRL_ACCESS: begin
        state_d    = ST_RUN;
        cfg_done_d = 1'b1;
      end
      ST_RUN: begin
        // Reconfiguration wins over draining; queued bytes survive it
        if (cfg_start) begin
          state_d     = ST_BAUD_SETUP;
          cfg_done_d  = 1'b0;
          bus_d.addr  = ADDR_BAUD;
          bus_d.wdata = DATA_W'(cfg_baud);
        end else if (!fifo_empty && !tx_busy) begin
          state_d     = ST_DATA_SETUP;
          fifo_pop    = 1'b1;
          bus_d.addr  = ADDR_DATA;
          bus_d.wdata = DATA_W'(fifo_head);
        end
      end
      ST_DATA_SETUP:  state_d = ST_DATA_ACCESS;
      ST_DATA_ACCESS: state_d = ST_DATA_GAP;
      // One idle cycle lets the UART raise tx_busy before RUN samples it
      ST_DATA_GAP:    state_d = ST_RUN;
      default:        state_d = ST_UNCFG;
    endcase

    unique case (state_d)
      ST_BAUD_SETUP, ST_CTRL_SETUP, ST_DATA_SETUP: begin
        bus_d.sel = 1'b1;
      end
      ST_BAUD_ACCESS, ST_CTRL_ACCESS, ST_DATA_ACCESS: begin
        bus_d.sel    = 1'b1;
        bus_d.enable = 1'b1;
      end
      default: begin
        bus_d.sel    = 1'b0;
        bus_d.enable = 1'b0;
      end
    endcase
    bus_d.write = bus_d.sel;

    idle_d = ((state_d == ST_UNCFG) || (state_d == ST_RUN)) && (fifo_lvl_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNCFG;
      bus_q      <= '0;
      cfg_done_q <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      cfg_done_q <= cfg_done_d;
      idle_q     <= idle_d;
    end
  end

  assign sel        = bus_q.sel;
  assign enable     = bus_q.enable;
  assign write      = bus_q.write;
  assign addr       = bus_q.addr;
  assign wdata      = bus_q.wdata;
  assign cfg_done   = cfg_done_q;
  assign idle       = idle_q;
  assign byte_ready = fifo_ready;
  assign fifo_level = fifo_lvl;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: configuration writes, data draining,
// FIFO full back-pressure, pre-config buffering, cfg_start filtering and
// asynchronous reset mid-transfer.
module tb_uart_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [15:0] cfg_baud;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        tx_busy;
  logic        sel;
  logic        enable;
  logic [9:0]  addr;
  logic        write;
  logic [31:0] wdata;
  logic        cfg_done;
  logic [2:0]  fifo_level;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx_sequencer #(
    .FIFO_DEPTH (4),
    .BAUD_W     (16),
    .CTRL_TX_EN (32'h0000_0001)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_baud   (cfg_baud),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .tx_busy    (tx_busy),
    .sel        (sel),
    .enable     (enable),
    .addr       (addr),
    .write      (write),
    .wdata      (wdata),
    .cfg_done   (cfg_done),
    .fifo_level (fifo_level),
    .idle       (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Push one byte; waits (bounded) for byte_ready
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (!byte_ready && n < 50) begin tick(); n++; end
    check("push_ready", 32'(byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_cfg(input logic [15:0] baud);
    cfg_start = 1'b1;
    cfg_baud  = baud;
    tick();
    cfg_start = 1'b0;
  endtask

  // Find the next SETUP cycle, check it and the following ACCESS cycle
  task automatic expect_xfer(input string tag, input logic [9:0] ea,
                             input logic [31:0] ew, output int c);
    int  n     = 0;
    logic found = 1'b0;
    while (n < 40 && !found) begin
      if (sel && !enable) found = 1'b1;
      else begin tick(); n++; end
    end
    check({tag, "_found"}, 32'(found), 32'd1);
    c = cyc;
    check({tag, "_setup_addr"}, 32'(addr), 32'(ea));
    check({tag, "_setup_wdata"}, wdata, ew);
    check({tag, "_setup_write"}, 32'(write), 32'd1);
    tick();
    check({tag, "_access_selen"}, 32'({sel, enable}), 32'd3);
    check({tag, "_access_addr"}, 32'(addr), 32'(ea));
    check({tag, "_access_wdata"}, wdata, ew);
  endtask

  // DATA write followed by the one-cycle gap
  task automatic expect_data(input string tag, input logic [7:0] b, output int c);
    expect_xfer(tag, 10'd0, {24'h0, b}, c);
    tick();
    check({tag, "_gap_sel"}, 32'({sel, enable}), 32'd0);
  endtask

  initial begin
    int p, c1, c2, seen;
    rst_n      = 1'b0;
    cfg_start  = 1'b0;
    cfg_baud   = 16'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    tx_busy    = 1'b0;

    // 1: reset values, configuration sequence
    tick(); tick();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    tick();
    p = cyc;
    pulse_cfg(16'd434);
    expect_xfer("t1_baud", 10'd4, 32'h0000_01B2, c1);
    check("t1_baud_cyc", 32'(c1 - p), 32'd1);
    expect_xfer("t1_ctrl", 10'd2, 32'h0000_0001, c2);
    check("t1_done_early", 32'(cfg_done), 32'd0);
    tick();
    check("t1_done", 32'(cfg_done), 32'd1);
    check("t1_done_cyc", 32'(cyc - p), 32'd5);
    check("t1_idle", 32'(idle), 32'd1);
    check("t1_sel_run", 32'(sel), 32'd0);

    // 2: two bytes, back-to-back spacing
    push_byte(8'h55);
    push_byte(8'hA3);
    expect_data("t2_b0", 8'h55, c1);
    expect_data("t2_b1", 8'hA3, c2);
    check("t2_spacing", 32'(c2 - c1), 32'd4);

    // 3: FIFO fills while transmitter busy
    tx_busy = 1'b1;
    tick();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("t3_level", 32'(fifo_level), 32'd4);
    check("t3_ready", 32'(byte_ready), 32'd0);
    check("t3_idle", 32'(idle), 32'd0);
    seen = 0;
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      if (sel) seen++;
      tick();
    end
    byte_valid = 1'b0;
    check("t3_level_blocked", 32'(fifo_level), 32'd4);
    check("t3_no_sel", 32'(seen), 32'd0);
    tx_busy = 1'b0;
    expect_data("t3_b0", 8'h11, c1);
    expect_data("t3_b1", 8'h22, c1);
    expect_data("t3_b2", 8'h33, c1);
    expect_data("t3_b3", 8'h44, c1);
    tick();
    check("t3_empty", 32'(fifo_level), 32'd0);

    // 4: bytes pushed while unconfigured wait for configuration
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (sel) seen++;
      tick();
    end
    check("t4_no_sel_uncfg", 32'(seen), 32'd0);
    check("t4_level", 32'(fifo_level), 32'd3);
    check("t4_cfg_done", 32'(cfg_done), 32'd0);
    pulse_cfg(16'd100);
    expect_xfer("t4_baud", 10'd4, 32'h0000_0064, c1);
    expect_xfer("t4_ctrl", 10'd2, 32'h0000_0001, c1);
    expect_data("t4_b0", 8'hC1, c1);
    expect_data("t4_b1", 8'hC2, c1);
    expect_data("t4_b2", 8'hC3, c1);

    // 5: cfg_start ignored mid-transfer, honoured in RUN
    push_byte(8'h5A);
    expect_xfer("t5_data", 10'd0, 32'h0000_005A, c1);
    pulse_cfg(16'd27);
    check("t5_gap_sel", 32'(sel), 32'd0);
    check("t5_done_kept", 32'(cfg_done), 32'd1);
    tick();
    check("t5_run_sel", 32'(sel), 32'd0);
    check("t5_run_idle", 32'(idle), 32'd1);
    pulse_cfg(16'd27);
    check("t5_done_cleared", 32'(cfg_done), 32'd0);
    expect_xfer("t5_baud", 10'd4, 32'h0000_001B, c1);
    check("t5_done_low_a", 32'(cfg_done), 32'd0);
    expect_xfer("t5_ctrl", 10'd2, 32'h0000_0001, c1);
    check("t5_done_low_b", 32'(cfg_done), 32'd0);
    tick();
    check("t5_done_high", 32'(cfg_done), 32'd1);

    // 6: async reset during DATA_SETUP
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    tick();
    byte_data  = 8'h78;
    tick();
    byte_valid = 1'b0;
    check("t6_setup_selen", 32'({sel, enable}), 32'd2);
    check("t6_level", 32'(fifo_level), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_sel", 32'(sel), 32'd0);
    check("t6_rst_enable", 32'(enable), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_done", 32'(cfg_done), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sel) seen++;
    end
    check("t6_uncfg_no_sel", 32'(seen), 32'd0);
    check("t6_uncfg_idle", 32'(idle), 32'd1);
    check("t6_uncfg_ready", 32'(byte_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Bus-master controller that sequences the UART register block over its sel/enable/addr[11:2] register interface. It programs BAUDDIV, then CTRL (TX enable), then drains a small internal byte FIFO into the DATA register, one byte per transmitter-idle window. It sits between a byte-producing client (CPU shim or test stream) and the UART address decoder/transmitter, replacing ad-hoc software register pokes.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2
BAUD_W, 16, width of the baud divisor written to BAUDDIV
CTRL_TX_EN, 32'h0000_0001, word written to CTRL to enable TX mode

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: (re)program BAUDDIV then CTRL
cfg_baud  in  BAUD_W  divisor, sampled on the cycle cfg_start is accepted
byte_valid  in  1  client byte offered
byte_data  in  8  client byte
byte_ready  out  1  FIFO not full; a byte is pushed when byte_valid && byte_ready
tx_busy  in  1  UART transmitter shifting a frame
sel  out  1  register-bus select
enable  out  1  register-bus access phase
addr  out  10  register word address, bits [11:2]
write  out  1  1 = write transfer (always 1 when sel=1)
wdata  out  32  write data
cfg_done  out  1  high once BAUDDIV and CTRL have been written since the last reset or cfg_start
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
idle  out  1  FSM in UNCFG or RUN with FIFO empty

Behaviour:
- Reset (rst_n=0, async): state UNCFG; sel=0, enable=0, addr=0, write=0, wdata=0, cfg_done=0, FIFO empty, fifo_level=0, byte_ready=1, idle=1.
- Address map (word addresses): DATA=10'd0 (byte 0x00), CTRL=10'd2 (0x08), BAUD=10'd4 (0x10).
- Every transfer is exactly two cycles: SETUP (sel=1, enable=0, addr/wdata/write valid), then ACCESS (sel=1, enable=1, same addr/wdata). The cycle after ACCESS drives sel=0, enable=0. There are no wait states.
- All bus outputs are registered; addr/wdata hold their value while sel=0.
- States: UNCFG, BAUD_SETUP, BAUD_ACCESS, CTRL_SETUP, CTRL_ACCESS, RUN, DATA_SETUP, DATA_ACCESS, DATA_GAP.
- UNCFG: wait. When cfg_start=1, latch cfg_baud, clear cfg_done, and go to BAUD_SETUP.
- BAUD_SETUP -> BAUD_ACCESS with wdata = zero-extended cfg_baud.
- BAUD_ACCESS -> CTRL_SETUP -> CTRL_ACCESS with wdata = CTRL_TX_EN.
- CTRL_ACCESS -> RUN; cfg_done=1 from the RUN entry cycle onward.
- RUN priority:
  - cfg_start=1: go to BAUD_SETUP (reconfigure). FIFO contents are kept.
  - Otherwise, FIFO non-empty and tx_busy=0: pop the head into wdata[7:0] (upper bits 0) and go to DATA_SETUP.
  - Otherwise stay in RUN.
- DATA_SETUP -> DATA_ACCESS -> DATA_GAP. DATA_GAP lasts one cycle so that tx_busy can assert, then returns to RUN. RUN does not start the next byte until tx_busy=0.
- cfg_start is ignored in every state except UNCFG and RUN. It is not queued.
- FIFO: push when byte_valid && byte_ready. Pop only on the RUN->DATA_SETUP transition. A simultaneous push and pop leaves the level unchanged and is legal even when full, except that byte_ready is low when full, so a push is blocked at full. Read and write pointers wrap modulo FIFO_DEPTH.
- Bytes are written to the UART in push order. No byte is dropped or duplicated.
- Bytes may be pushed in UNCFG; they are held until RUN.
- Async reset mid-transfer: sel and enable drop immediately, and FIFO contents are discarded.

Decomposition:
- Shared package uart_pkg holds:
  - register word-address constants ADDR_DATA=10'd0, ADDR_CTRL=10'd2, ADDR_BAUD=10'd4
  - state enum/localparams for this FSM
  - CTRL bit-field constants (TX_EN bit 0)
- One sub-module, uart_tx_fifo: synchronous FIFO parameterised by DEPTH and WIDTH=8, with push/pop/full/empty/level outputs and the async active-low reset. The sequencer holds the FSM and bus registers.

Test Plan:
1. Reset, then cfg_start with cfg_baud=16'd434 -> BAUD writes 0x1B2 at addr 4 (SETUP then ACCESS), CTRL writes 0x1 at addr 2, cfg_done rises 5 cycles after the pulse, idle=1.
2. After config, push 0x55, 0xA3 with tx_busy=0 -> DATA writes 0x55 then 0xA3 at addr 0. The second SETUP starts no earlier than 4 cycles after the first.
3. Hold tx_busy=1, push 4 bytes -> byte_ready=0 and fifo_level=4, a 5th push is blocked, no sel activity. Release tx_busy -> all 4 bytes emitted in order.
4. Push 3 bytes before cfg_start -> none are sent in UNCFG. After config, all 3 are sent in order following the CTRL write.
5. Pulse cfg_start during DATA_ACCESS -> ignored, the transfer completes. Pulse again in RUN with baud 16'd27 -> BAUD rewritten to 0x1B, cfg_done low until CTRL_ACCESS completes.
6. Assert rst_n=0 during DATA_SETUP -> sel and enable are 0 in the same cycle, fifo_level=0, and the state after release is UNCFG.
